// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch buffer: sequential fetch over a variable-latency memory port,
// PC-tagged FIFO toward IF/ID, and redirect flush with stale-response discard.
module inst_prefetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 6,
  parameter int unsigned DW    = 16
) (
  input  logic                       clk,
  input  logic                       clear,
  output logic                       mem_req,
  output logic [AW-1:0]              mem_addr,
  input  logic                       mem_rvalid,
  input  logic [DW-1:0]              mem_rdata,
  output logic                       out_valid,
  output logic [DW-1:0]              out_inst,
  output logic [AW-1:0]              out_pc,
  input  logic                       out_ready,
  input  logic                       redirect,
  input  logic [AW-1:0]              redirect_pc,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] req_pc;
  logic          busy;
  logic          discard;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [DW-1:0] inst_mem [DEPTH];
  logic [AW-1:0] pc_mem   [DEPTH];

  logic          issue;
  logic          push;
  logic          pop;
  logic [CW-1:0] count_nxt;

  // Space for the response is reserved at issue, so a push can never overflow.
  always_comb begin
    issue     = !redirect && !busy && (count < CW'(DEPTH));
    push      = !redirect && busy && mem_rvalid && !discard;
    pop       = !redirect && out_valid && out_ready;
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + CW'(1);
    end else if (pop && !push) begin
      count_nxt = count - CW'(1);
    end
  end

  // First-word fall-through head.
  assign out_inst = inst_mem[rd_ptr];
  assign out_pc   = pc_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!clear) begin
      fetch_pc  <= '0;
      req_pc    <= '0;
      busy      <= 1'b0;
      discard   <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        inst_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (redirect) begin
      // Flush and restart; an in-flight request is either dropped now or marked stale.
      fetch_pc  <= redirect_pc;
      mem_req   <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      if (busy) begin
        if (mem_rvalid) begin
          busy <= 1'b0;
        end else begin
          discard <= 1'b1;
        end
      end
    end else begin
      mem_req <= issue;
      if (issue) begin
        mem_addr <= fetch_pc;
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + AW'(1);
        busy     <= 1'b1;
      end else if (busy && mem_rvalid) begin
        busy    <= 1'b0;
        discard <= 1'b0;
      end
      if (push) begin
        inst_mem[wr_ptr] <= mem_rdata;
        pc_mem[wr_ptr]   <= req_pc;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count     <= count_nxt;
      out_valid <= (count_nxt != '0);
    end
  end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed bench for inst_prefetch_queue: latency-programmable memory responder,
// scoreboard of expected {pc, inst} entries, address-sequence and occupancy checks.
module tb_inst_prefetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 6;
  localparam int unsigned DW    = 16;

  logic          clk = 1'b0;
  logic          clear;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          out_valid;
  logic [DW-1:0] out_inst;
  logic [AW-1:0] out_pc;
  logic          out_ready;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic [2:0]    count;

  inst_prefetch_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .clear      (clear),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .out_valid  (out_valid),
    .out_inst   (out_inst),
    .out_pc     (out_pc),
    .out_ready  (out_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .count      (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] inst;
  } exp_t;

  exp_t          q[$];
  logic [AW-1:0] pop_log[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            lat = 1;
  int            wait_cnt = 0;
  int            n_req = 0;
  int            n_pops = 0;
  bit            pend = 1'b0;
  bit            stale = 1'b0;
  logic [AW-1:0] paddr = '0;
  logic [AW-1:0] exp_addr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] log_at(input int i);
    return (i < pop_log.size()) ? 32'(pop_log[i]) : 32'hFFFF_FFFF;
  endfunction

  // One clock: model the edge's effect, advance, check occupancy, then run the responder.
  task automatic tick();
    exp_t e;
    if (!clear) begin
      q.delete(); pend = 1'b0; stale = 1'b0; exp_addr = '0;
    end else if (redirect) begin
      q.delete();
      if (pend) stale = 1'b1;
      exp_addr = redirect_pc;
    end else if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("sb_unexpected_pop", 32'(out_pc), 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("sb_pc", 32'(out_pc), 32'(e.pc));
        chk("sb_inst", 32'(out_inst), 32'(e.inst));
        pop_log.push_back(out_pc);
        n_pops++;
      end
    end
    @(posedge clk); #1;
    chk("count", 32'(count), 32'(q.size()));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    mem_rvalid = 1'b0;
    if (!clear) begin
      pend = 1'b0;
    end else if (pend) begin
      if (wait_cnt <= 1) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 16'h1000 + 16'(paddr);
        pend       = 1'b0;
        if (stale) stale = 1'b0;
        else q.push_back('{pc: paddr, inst: 16'h1000 + 16'(paddr)});
      end else begin
        wait_cnt--;
      end
    end
    if (mem_req) begin
      chk("one_outstanding", 32'(pend), 32'd0);
      chk("mem_addr_seq", 32'(mem_addr), 32'(exp_addr));
      exp_addr = exp_addr + AW'(1);
      pend     = 1'b1;
      paddr    = mem_addr;
      wait_cnt = lat;
      n_req++;
    end
  endtask

  task automatic do_reset();
    clear = 1'b0;
    repeat (2) begin
      redirect    = 1'($urandom);
      redirect_pc = AW'($urandom);
      out_ready   = 1'($urandom);
      tick();
    end
    redirect = 1'b0;
  endtask

  initial begin
    clear = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = '0;

    // 1: reset with random inputs, then first request at address 0
    do_reset();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_out_inst", 32'(out_inst), 32'd0);
    chk("rst_out_pc", 32'(out_pc), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    lat = 1; out_ready = 1'b1; clear = 1'b1;
    tick();
    chk("first_req", 32'(mem_req), 32'd1);
    chk("first_addr", 32'(mem_addr), 32'd0);

    // 2: streaming at latency 1
    n_pops = 0;
    repeat (24) tick();
    chk("stream_pops", 32'(n_pops >= 7), 32'd1);

    // 3: backpressure fills exactly DEPTH entries, then drains in order and resumes
    do_reset();
    lat = 1; out_ready = 1'b0; clear = 1'b1; n_req = 0;
    repeat (20) tick();
    chk("bp_count", 32'(count), 32'd4);
    chk("bp_reqs", 32'(n_req), 32'd4);
    chk("bp_req_idle", 32'(mem_req), 32'd0);
    chk("bp_head_pc", 32'(out_pc), 32'd0);
    chk("bp_head_inst", 32'(out_inst), 32'h1000);
    out_ready = 1'b1; n_pops = 0; pop_log.delete();
    repeat (16) tick();
    chk("bp_pop0", log_at(0), 32'd0);
    chk("bp_pop3", log_at(3), 32'd3);
    chk("bp_resumed", 32'(n_req > 4), 32'd1);

    // 4: redirect while a latency-3 fetch is outstanding
    do_reset();
    lat = 3; out_ready = 1'b1; clear = 1'b1;
    tick(); tick();
    redirect = 1'b1; redirect_pc = 6'h20;
    tick();
    redirect = 1'b0;
    chk("rd_flush_count", 32'(count), 32'd0);
    pop_log.delete();
    for (int i = 0; i < 12 && !mem_req; i++) tick();
    chk("rd_new_req", 32'(mem_req), 32'd1);
    chk("rd_new_addr", 32'(mem_addr), 32'h20);
    repeat (12) tick();
    chk("rd_first_pc", log_at(0), 32'h20);

    // 5: redirect on the same edge as the response
    lat = 2;
    for (int i = 0; i < 12 && !mem_rvalid; i++) tick();
    chk("same_edge_rvalid", 32'(mem_rvalid), 32'd1);
    redirect = 1'b1; redirect_pc = 6'h10;
    tick();
    redirect = 1'b0;
    chk("same_edge_noreq", 32'(mem_req), 32'd0);
    tick();
    chk("same_edge_req", 32'(mem_req), 32'd1);
    chk("same_edge_addr", 32'(mem_addr), 32'h10);

    // 6: PC wrap 62,63,0,1
    lat = 1;
    redirect = 1'b1; redirect_pc = 6'd62;
    tick();
    redirect = 1'b0;
    pop_log.delete();
    repeat (20) tick();
    chk("wrap0", log_at(0), 32'd62);
    chk("wrap1", log_at(1), 32'd63);
    chk("wrap2", log_at(2), 32'd0);
    chk("wrap3", log_at(3), 32'd1);

    // 7: clear during a wait with two entries buffered
    do_reset();
    lat = 3; out_ready = 1'b0; clear = 1'b1;
    for (int i = 0; i < 40 && !(count == 3'd2 && mem_req); i++) tick();
    chk("mid_setup", 32'(count == 3'd2 && mem_req), 32'd1);
    clear = 1'b0;
    tick();
    chk("mid_rst_req", 32'(mem_req), 32'd0);
    chk("mid_rst_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_inst", 32'(out_inst), 32'd0);
    chk("mid_rst_pc", 32'(out_pc), 32'd0);
    clear = 1'b1; out_ready = 1'b1;
    tick();
    chk("mid_restart_req", 32'(mem_req), 32'd1);
    chk("mid_restart_addr", 32'(mem_addr), 32'd0);
    pop_log.delete();
    repeat (20) tick();
    chk("mid_first_pc", log_at(0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
